// File: rtl/timer_alarm.sv
// timer_alarm: compare/alarm unit that watches a free-running count and raises a sticky irq,
// with one-shot or periodic auto-reload and overrun flagging.
module timer_alarm #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] count_in_i,
  input  logic         wr_en_i,
  input  logic [1:0]   wr_addr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic [1:0]   rd_addr_i,
  output logic [W-1:0] rd_data_o,
  output logic         irq_o,
  output logic         overrun_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] FIRED = 2'd2;
  logic [W-1:0] cmp_q, cmp_d, period_q, period_d;
  logic         arm_q, arm_d, periodic_q, periodic_d, irq_q, irq_d, ovr_q, ovr_d;
  logic [1:0]   state_q, state_d;
  logic         wr_cmp, wr_per, wr_ctrl, wr_ack, ack_irq, ack_ovr, match, reload;
  always_comb begin
    wr_cmp  = wr_en_i && wr_addr_i == 2'd0;
    wr_per  = wr_en_i && wr_addr_i == 2'd1;
    wr_ctrl = wr_en_i && wr_addr_i == 2'd2;
    wr_ack  = wr_en_i && wr_addr_i == 2'd3;
    ack_irq = wr_ack && wr_data_i[0];
    ack_ovr = wr_ack && wr_data_i[1];
    match   = state_q == ARMED && count_in_i == cmp_q;
    // A zero period cannot advance CMP, so it degrades to one-shot.
    reload  = match && periodic_q && period_q != '0;
    cmp_d      = wr_cmp ? wr_data_i : reload ? cmp_q + period_q : cmp_q;
    period_d   = wr_per ? wr_data_i : period_q;
    periodic_d = wr_ctrl ? wr_data_i[1] : periodic_q;
    arm_d      = wr_ctrl ? wr_data_i[0] : (match && !reload) ? 1'b0 : arm_q;
    irq_d      = match ? 1'b1 : ack_irq ? 1'b0 : irq_q;
    ovr_d      = (match && irq_q && !ack_irq) ? 1'b1 : ack_ovr ? 1'b0 : ovr_q;
    state_d    = wr_ctrl ? (wr_data_i[0] ? ARMED : IDLE)
               : (match && !reload) ? FIRED
               : (state_q == FIRED && ack_irq) ? IDLE
               : state_q;
    rd_data_o  = rd_addr_i == 2'd0 ? cmp_q
               : rd_addr_i == 2'd1 ? period_q
               : rd_addr_i == 2'd2 ? {{(W-4){1'b0}}, state_q, periodic_q, arm_q}
               : {{(W-2){1'b0}}, ovr_q, irq_q};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q      <= '0;
      period_q   <= '0;
      arm_q      <= 1'b0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      ovr_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      arm_q      <= arm_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      ovr_q      <= ovr_d;
      state_q    <= state_d;
    end
  end
  assign irq_o     = irq_q;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_timer_alarm.sv
// tb_timer_alarm: scoreboard bench for timer_alarm; expectations queued with stimulus,
// drained and compared after each clock edge.
module tb_timer_alarm;
  localparam int S_IRQ = 4;
  localparam int S_OVR = 5;
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } ent_t;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] count_in_i = '0;
  logic        wr_en_i = 1'b0;
  logic [1:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [1:0]  rd_addr_i = '0;
  logic [31:0] rd_data_o;
  logic        irq_o, overrun_o;
  ent_t        sb[$];
  int          errs = 0;
  int          checks = 0;
  timer_alarm #(.W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .count_in_i(count_in_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .irq_o(irq_o), .overrun_o(overrun_o)
  );
  always #10 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb.push_back('{tag, sel, exp});
  endtask
  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel < 4) rd_addr_i = 2'(e.sel);
      #1;
      chk(e.tag, e.sel == S_IRQ ? {31'b0, irq_o} : e.sel == S_OVR ? {31'b0, overrun_o} : rd_data_o, e.exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic wr_at(input logic [31:0] c, input logic [1:0] a, input logic [31:0] d);
    count_in_i = c;
    wr_en_i = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_at(count_in_i, a, d);
  endtask
  task automatic cnt(input logic [31:0] c);
    count_in_i = c;
    tick();
  endtask
  // Periodic run with ACK after every fire; model tracks the reloading compare value.
  task automatic periodic_run(input string tag, input logic [31:0] start, input int n,
                              input logic [31:0] cmp0, input logic [31:0] per);
    logic [31:0] mcmp, c;
    bit fire;
    mcmp = cmp0;
    for (int i = 0; i < n; i++) begin
      c = start + 32'(i);
      fire = (c == mcmp);
      if (fire) mcmp = mcmp + per;
      cnt(c);
      push({tag, "_irq"}, S_IRQ, {31'b0, fire});
      if (fire) push({tag, "_cmp"}, 0, mcmp);
      drain();
      if (fire) wr(2'd3, 32'h1);
    end
    push({tag, "_ovr"}, S_OVR, 0);
    drain();
  endtask
  initial begin
    #3;
    push("rst_irq", S_IRQ, 0); push("rst_ovr", S_OVR, 0); push("rst_cmp", 0, 0);
    push("rst_per", 1, 0); push("rst_ctrl", 2, 0); push("rst_stat", 3, 0);
    drain();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    // one-shot
    count_in_i = 0;
    wr(2'd0, 20);
    wr(2'd2, 1);
    push("os_ctrl_armed", 2, 32'h5);
    drain();
    for (int c = 0; c <= 40; c++) begin
      cnt(32'(c));
      push("os_irq", S_IRQ, {31'b0, c >= 20});
      drain();
    end
    push("os_ctrl_fired", 2, 32'h8); push("os_ovr", S_OVR, 0);
    drain();
    wr(2'd3, 1);
    push("os_ack_irq", S_IRQ, 0); push("os_ack_ctrl", 2, 0);
    drain();
    // periodic
    count_in_i = 0;
    wr(2'd0, 10);
    wr(2'd1, 5);
    wr(2'd2, 3);
    push("per_ctrl", 2, 32'h7);
    drain();
    periodic_run("per", 0, 23, 10, 5);
    push("per_cmp_end", 0, 25);
    drain();
    wr(2'd2, 0);
    // overrun
    count_in_i = 0;
    wr(2'd0, 5);
    wr(2'd1, 3);
    wr(2'd2, 3);
    for (int c = 0; c <= 8; c++) begin
      cnt(32'(c));
      push("ovr_irq", S_IRQ, {31'b0, c >= 5});
      push("ovr_ovr", S_OVR, {31'b0, c >= 8});
      drain();
    end
    wr(2'd3, 3);
    push("ovr_ack_irq", S_IRQ, 0); push("ovr_ack_ovr", S_OVR, 0);
    drain();
    wr(2'd2, 0);
    // wrap
    count_in_i = 0;
    wr(2'd0, 32'hFFFF_FFFE);
    wr(2'd1, 4);
    wr(2'd2, 3);
    periodic_run("wrap", 32'hFFFF_FFF0, 20, 32'hFFFF_FFFE, 4);
    push("wrap_cmp_end", 0, 32'h6);
    drain();
    wr(2'd2, 0);
    // collisions
    count_in_i = 0;
    wr(2'd0, 30);
    wr(2'd1, 10);
    wr(2'd2, 3);
    cnt(30);
    push("col_first_irq", S_IRQ, 1);
    drain();
    wr_at(40, 2'd3, 1);
    push("col_ack_irq", S_IRQ, 1); push("col_ack_ovr", S_OVR, 0); push("col_ack_cmp", 0, 50);
    drain();
    wr_at(45, 2'd3, 3);
    wr_at(50, 2'd0, 100);
    push("col_cmpw_irq", S_IRQ, 1); push("col_cmpw_ovr", S_OVR, 0); push("col_cmpw_cmp", 0, 100);
    drain();
    wr_at(60, 2'd3, 3);
    wr_at(100, 2'd2, 0);
    push("col_ctrl_irq", S_IRQ, 1); push("col_ctrl_state", 2, 0);
    drain();
    // asynchronous reset mid-run
    wr(2'd2, 3);
    wr_at(110, 2'd0, 77);
    #2;
    rst_ni = 1'b0;
    push("arst_irq", S_IRQ, 0); push("arst_ovr", S_OVR, 0);
    push("arst_cmp", 0, 0); push("arst_ctrl", 2, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
